// File: rtl/cpu_datapath.sv
// cpu_datapath: PC, IR, register file, accumulator, ALU and flag register driven by the CPU controller strobes.
// Define REGFILE_RESET_EN to clear the register file on reset.
module cpu_datapath #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8,
   parameter int NREG   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              LoadIR,
   input  logic              IncPC,
   input  logic              SelPC,
   input  logic              LoadPC,
   input  logic              LoadReg,
   input  logic              DumpReg,
   input  logic              LoadAcc,
   input  logic [1:0]        SelAcc,
   input  logic [3:0]        SelALU,
   input  logic [3:0]        SelReg,
   input  logic [7:0]        imem_data,
   output logic [PC_W-1:0]   imem_addr,
   output logic [7:0]        Opcode,
   output logic              Zero_Carry,
   output logic [DATA_W-1:0] acc_out
);
   logic [PC_W-1:0]   r_pc;
   logic [7:0]        r_ir;
   logic [DATA_W-1:0] r_acc;
   logic              r_zc;
   logic [DATA_W-1:0] r_reg [NREG];
   logic [DATA_W-1:0] w_a, w_b, w_imm_d, w_acc_nx;
   logic [PC_W-1:0]   w_imm_pc;
   logic [DATA_W:0]   w_alu;
   logic              w_cop, w_acc_we, w_zc_nx;

   assign w_a       = r_acc;
   assign w_b       = DumpReg ? r_reg[SelReg] : '0;
   assign w_imm_d   = DATA_W'(r_ir[3:0]);
   assign w_imm_pc  = PC_W'(r_ir[3:0]);
   assign w_cop     = SelALU inside {4'h1, 4'h2, 4'h7, 4'h8, 4'h9, 4'hA};
   assign w_acc_we  = LoadAcc && SelAcc != 2'b11;
   assign w_acc_nx  = SelAcc == 2'b00 ? w_alu[DATA_W-1:0] : SelAcc == 2'b01 ? w_imm_d : '0;
   assign w_zc_nx   = (SelAcc == 2'b00 && w_cop) ? w_alu[DATA_W] : |w_acc_nx;
   assign imem_addr = r_pc;
   assign Opcode    = r_ir;
   assign Zero_Carry = r_zc;
   assign acc_out   = r_acc;

   // Bit DATA_W is carry, or borrow for SUB/DEC since the zero-extended difference wraps.
   always_comb begin
      w_alu = {1'b0, w_a};
      case (SelALU)
         4'h0: w_alu = {1'b0, w_b};
         4'h1: w_alu = {1'b0, w_a} + {1'b0, w_b};
         4'h2: w_alu = {1'b0, w_a} - {1'b0, w_b};
         4'h3: w_alu = {1'b0, w_a & w_b};
         4'h4: w_alu = {1'b0, w_a | w_b};
         4'h5: w_alu = {1'b0, w_a ^ w_b};
         4'h6: w_alu = {1'b0, ~w_a};
         4'h7: w_alu = {w_a, 1'b0};
         4'h8: w_alu = {w_a[0], 1'b0, w_a[DATA_W-1:1]};
         4'h9: w_alu = {1'b0, w_a} + (DATA_W+1)'(1);
         4'hA: w_alu = {1'b0, w_a} - (DATA_W+1)'(1);
         default: w_alu = {1'b0, w_a};
      endcase
   end

   always_ff @(posedge clk)
      if (!reset) begin
         r_pc  <= '0;
         r_ir  <= '0;
         r_acc <= '0;
         r_zc  <= 1'b0;
      end else begin
         if (LoadIR) r_ir <= imem_data;
         if (LoadPC) r_pc <= IncPC ? r_pc + PC_W'(1) : SelPC ? w_imm_pc : PC_W'(r_reg[SelReg]);
         else if (IncPC) r_pc <= r_pc + PC_W'(1);
         if (w_acc_we) begin
            r_acc <= w_acc_nx;
            r_zc  <= w_zc_nx;
         end
      end

`ifdef REGFILE_RESET_EN
   always_ff @(posedge clk)
      if (!reset) for (int i = 0; i < NREG; i++) r_reg[i] <= '0;
      else if (LoadReg) r_reg[SelReg] <= r_acc;
`else
   always_ff @(posedge clk)
      if (LoadReg) r_reg[SelReg] <= r_acc;
`endif
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed scoreboard bench for cpu_datapath; expectations queued at drive time, checked after each edge.
module tb_cpu_datapath;
   typedef struct {
      logic [7:0] pc, ir, acc;
      logic       zc;
   } exp_t;

   logic       clk = 0, reset = 0;
   logic       LoadIR = 0, IncPC = 0, SelPC = 0, LoadPC = 0, LoadReg = 0, DumpReg = 0, LoadAcc = 0;
   logic [1:0] SelAcc = 0;
   logic [3:0] SelALU = 0, SelReg = 0;
   logic [7:0] imem_data = 0, imem_addr, Opcode, acc_out;
   logic       Zero_Carry;
   exp_t       sb[$];
   int         n_cmp = 0, n_bad = 0, n_step = 0;

   cpu_datapath dut (
      .clk(clk), .reset(reset), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
      .LoadReg(LoadReg), .DumpReg(DumpReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
      .SelReg(SelReg), .imem_data(imem_data), .imem_addr(imem_addr), .Opcode(Opcode),
      .Zero_Carry(Zero_Carry), .acc_out(acc_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic rst, lir, inc, spc, lpc, lreg, dump, lacc,
                       input logic [1:0] sacc, input logic [3:0] alu, sreg, input logic [7:0] imem,
                       input logic [7:0] e_pc, e_ir, e_acc, input logic e_zc);
      exp_t e;
      reset = rst; LoadIR = lir; IncPC = inc; SelPC = spc; LoadPC = lpc; LoadReg = lreg;
      DumpReg = dump; LoadAcc = lacc; SelAcc = sacc; SelALU = alu; SelReg = sreg; imem_data = imem;
      e = '{pc: e_pc, ir: e_ir, acc: e_acc, zc: e_zc};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("s%0d_pc", n_step), imem_addr, e.pc);
      chk($sformatf("s%0d_ir", n_step), Opcode, e.ir);
      chk($sformatf("s%0d_acc", n_step), acc_out, e.acc);
      chk($sformatf("s%0d_zc", n_step), {7'b0, Zero_Carry}, {7'b0, e.zc});
      n_step++;
   endtask

   initial begin
      //   rst lir inc spc lpc lrg dmp lac sacc  alu    sreg   imem     pc     ir     acc   zc
      step(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 4'h0, 4'd0, 8'h43, 8'h01, 8'h43, 8'h00, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0, 4'd0, 8'h0A, 8'h01, 8'h0A, 8'h00, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 2'd1, 4'h0, 4'd0, 8'h00, 8'h01, 8'h0A, 8'h0A, 1);
      step(1, 0, 0, 0, 0, 1, 0, 0, 2'd0, 4'h0, 4'd3, 8'h00, 8'h01, 8'h0A, 8'h0A, 1);
      step(1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'h0, 4'd0, 8'h07, 8'h01, 8'h07, 8'h0A, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 2'd1, 4'h0, 4'd0, 8'h00, 8'h01, 8'h07, 8'h07, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 4'h6, 4'd0, 8'h00, 8'h01, 8'h07, 8'hF8, 1);
      step(1, 0, 0, 0, 0, 0, 1, 1, 2'd0, 4'h1, 4'd3, 8'h00, 8'h01, 8'h07, 8'h02, 1);
      step(1, 0, 0, 0, 0, 1, 0, 0, 2'd0, 4'h0, 4'd4, 8'h00, 8'h01, 8'h07, 8'h02, 1);
      step(1, 0, 0, 0, 0, 0, 1, 1, 2'd0, 4'h2, 4'd4, 8'h00, 8'h01, 8'h07, 8'h00, 0);
      step(1, 0, 0, 1, 1, 0, 0, 0, 2'd0, 4'h0, 4'd0, 8'h00, 8'h07, 8'h07, 8'h00, 0);
      step(1, 0, 1, 1, 1, 0, 0, 0, 2'd0, 4'h0, 4'd0, 8'h00, 8'h08, 8'h07, 8'h00, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 4'h0, 4'd3, 8'h00, 8'h0A, 8'h07, 8'h00, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 4'hA, 4'd0, 8'h00, 8'h0A, 8'h07, 8'hFF, 1);
      step(1, 0, 0, 0, 0, 1, 0, 0, 2'd0, 4'h0, 4'd5, 8'h00, 8'h0A, 8'h07, 8'hFF, 1);
      step(1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 4'h0, 4'd5, 8'h00, 8'hFF, 8'h07, 8'hFF, 1);
      step(1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 4'h0, 4'd0, 8'h00, 8'h00, 8'h07, 8'hFF, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 2'd3, 4'h1, 4'd0, 8'h00, 8'h00, 8'h07, 8'hFF, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 4'h7, 4'd0, 8'h00, 8'h00, 8'h07, 8'hFE, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 4'h8, 4'd0, 8'h00, 8'h00, 8'h07, 8'h7F, 0);
      step(1, 0, 0, 0, 0, 1, 0, 1, 2'd2, 4'h0, 4'd6, 8'h00, 8'h00, 8'h07, 8'h00, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 4'h0, 4'd6, 8'h00, 8'h7F, 8'h07, 8'h00, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 2'd1, 4'h0, 4'd0, 8'h00, 8'h7F, 8'h07, 8'h07, 1);
      step(0, 1, 0, 1, 1, 0, 0, 1, 2'd1, 4'h0, 4'd0, 8'h55, 8'h00, 8'h00, 8'h00, 0);
`ifdef REGFILE_RESET_EN
      step(1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 4'h0, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 0);
`else
      step(1, 0, 0, 0, 1, 0, 0, 0, 2'd0, 4'h0, 4'd3, 8'h00, 8'h0A, 8'h00, 8'h00, 0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath responder to the CPU controller. It consumes the controller's control strobes: LoadIR, IncPC, SelPC, LoadPC, LoadReg, DumpReg, LoadAcc, SelAcc, SelALU and SelReg.
- It returns the current Opcode and the Zero_Carry flag to the controller.
- It holds the program counter, instruction register, a 16-entry register file, the accumulator, an ALU and the flag register.
- It drives the instruction-memory address and reads the instruction byte back.

Parameters:
- DATA_W, 8: accumulator, register and ALU width.
- PC_W, 8: program counter width; also the instruction memory address width.
- NREG, 16: register file depth, indexed by SelReg[3:0].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- LoadIR  in  1  capture imem_data into the IR.
- IncPC  in  1  PC increment request.
- SelPC  in  1  PC load source: 0 = register bus, 1 = immediate.
- LoadPC  in  1  PC load request.
- LoadReg  in  1  write the accumulator into reg[SelReg].
- DumpReg  in  1  drive reg[SelReg] onto the register bus.
- LoadAcc  in  1  accumulator write enable.
- SelAcc  in  2  accumulator source select.
- SelALU  in  4  ALU operation select.
- SelReg  in  4  register file index.
- imem_data  in  8  instruction byte at imem_addr; asynchronous ROM.
- imem_addr  out  PC_W  equals PC, combinational.
- Opcode  out  8  equals IR, registered.
- Zero_Carry  out  1  flag register.
- acc_out  out  DATA_W  accumulator value, for debug and verification.

Behaviour:
- Reset (reset==0 at a clk edge): PC=0, IR=0, ACC=0, ZC=0. The register file is cleared only when REGFILE_RESET_EN is defined. Reset overrides every strobe and takes effect mid-instruction.
- Immediate value: imm = {4'b0, IR[3:0]}, zero-extended to DATA_W/PC_W.
- Register bus: rbus = DumpReg ? reg[SelReg] : 0.
- IR: on LoadIR, IR <= imem_data; otherwise IR holds.
- PC priority:
  - LoadPC & IncPC: PC+1. This is the controller's not-taken jump.
  - LoadPC & !IncPC: SelPC ? imm : reg[SelReg]. The register is read directly; DumpReg is not required.
  - IncPC only: PC+1.
  - Otherwise: hold.
  - Increment wraps modulo 2^PC_W, so 0xFF -> 0x00.
- LoadIR and IncPC in the same cycle: IR captures the byte at the old PC, and PC then advances. There is no extra latency.
- Register file: on LoadReg, reg[SelReg] <= ACC (pre-edge value). LoadReg and LoadAcc in the same cycle write the old ACC. A read of an index being written in the same cycle returns the old contents.
- ALU, combinational, with A = ACC and B = rbus. Result is 9 bits; bit 8 is the carry.
  - 0000 PASS B
  - 0001 ADD A+B
  - 0010 SUB A-B; carry = borrow
  - 0011 AND
  - 0100 OR
  - 0101 XOR
  - 0110 NOT A
  - 0111 SHL A; carry = A[7]
  - 1000 SHR A; carry = A[0]
  - 1001 INC A
  - 1010 DEC A; carry = borrow
  - 1011-1111 PASS A
- ACC: on LoadAcc, SelAcc selects the new value:
  - 00: ALU[7:0]
  - 01: imm
  - 10: 0
  - 11: hold
- ZC updates only on LoadAcc with SelAcc != 11:
  - Carry ops (ADD, SUB, SHL, SHR, INC, DEC) with SelAcc=00: ZC = carry.
  - All other loads: ZC = |new ACC. ZC=0 therefore means a zero result.
  - Otherwise ZC holds.
- Opcode and Zero_Carry are registered outputs, stable for a full cycle after each edge. imem_addr follows PC combinationally.

Optional Feature:
- Macro REGFILE_RESET_EN.
- Defined: all NREG registers are cleared to 0 by reset.
- Undefined: register contents are not reset; they power up X in simulation. This saves reset fan-out.
- PC, IR, ACC and ZC are reset in both builds.

Test Plan:
- Reset, then LoadIR=1 and IncPC=1 with imem_data=0x43 -> next cycle Opcode=0x43, imem_addr=0x01, ACC=0, Zero_Carry=0.
- IR=0x0A, LoadAcc=1, SelAcc=01 -> ACC=0x0A and ZC=1. Then LoadReg=1, SelReg=3 -> reg[3]=0x0A.
- ACC=0xF8, reg[3]=0x0A, DumpReg=1, SelReg=3, SelALU=0001, LoadAcc=1, SelAcc=00 -> ACC=0x02 and ZC=1 (carry). Repeat with SUB: ACC=0x02, reg=0x02 -> ACC=0x00 and ZC=0.
- Jumps:
  - IR=0x07, LoadPC=1, SelPC=1, IncPC=0 -> PC=0x07.
  - LoadPC=1, IncPC=1 at PC=0x07 -> PC=0x08.
  - SelPC=0 with reg[3]=0x0A -> PC=0x0A.
- Wrap: PC=0xFF, IncPC=1 -> PC=0x00, imem_addr=0x00.
- Reset mid-operation: assert reset=0 while LoadAcc and LoadPC are high -> PC=0, ACC=0, IR=0, ZC=0 next edge. With REGFILE_RESET_EN defined, reg[3]=0; without it, reg[3] keeps 0x0A.
